// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, coordinate type and range helper.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // 640x480@60 defaults
    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam int DEF_SYNC_DELAY = 1;

    localparam int DEF_H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;   // exclusive
    localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;   // exclusive

    // lo <= v < hi
    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate bus from the timing source to the sprite/ROM renderers.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t DrawX;
    coord_t DrawY;
    logic   blank;
    logic   hs;
    logic   vs;
    logic   sync;
    logic   frame_start;
    logic   line_start;

    modport master (output DrawX, DrawY, blank, hs, vs, sync, frame_start, line_start);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, sync, frame_start, line_start);
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Free-running shift register with all-ones reset; DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        wire unused_ok = &{1'b0, clk, reset_n};
        assign q = d;
    end else begin : g_shift
        logic [DEPTH-1:0][WIDTH-1:0] stage_d, stage_q;

        // shift one stage per clock; stage 0 takes the input
        always_comb begin
            stage_d[0] = d;
            for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end

        // reset fills with inactive (high) sync so no stale pulse leaks out
        always_ff @(posedge clk) begin
            if (!reset_n) stage_q <= '1;
            else          stage_q <= stage_d;
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster position counters plus blank/sync/pulse decode for one display.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              pix_ce,
    vga_timing_gen_if.master  vif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024) begin : g_err_h
        $error("H_TOTAL does not fit the 10-bit column counter");
    end
    if (V_TOTAL > 1024) begin : g_err_v
        $error("V_TOTAL does not fit the 10-bit row counter");
    end
    if (SYNC_DELAY > 4 || SYNC_DELAY < 0) begin : g_err_d
        $error("SYNC_DELAY must be 0..4");
    end

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t hc_d, hc_q, vc_d, vc_q;
    coord_t hc_nx, vc_nx;
    logic   blank_d, blank_q;
    logic   hs_raw_d, hs_raw_q;
    logic   vs_raw_d, vs_raw_q;
    logic   frame_start_d, frame_start_q;
    logic   line_start_d, line_start_q;
    logic [1:0] sync_dly;

    // advance position and decode flags from the position being entered
    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        blank_d       = blank_q;
        hs_raw_d      = hs_raw_q;
        vs_raw_d      = vs_raw_q;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;

        hc_nx = (hc_q == H_LAST) ? '0 : hc_q + coord_t'(1);
        vc_nx = vc_q;
        if (hc_q == H_LAST) vc_nx = (vc_q == V_LAST) ? '0 : vc_q + coord_t'(1);

        if (pix_ce) begin
            hc_d          = hc_nx;
            vc_d          = vc_nx;
            blank_d       = (hc_nx < H_VIS) && (vc_nx < V_VIS);
            hs_raw_d      = !in_range(hc_nx, HS_START, HS_END);
            vs_raw_d      = !in_range(vc_nx, VS_START, VS_END);
            line_start_d  = (hc_nx == '0);
            frame_start_d = (hc_nx == '0) && (vc_nx == '0);
        end
    end

    // state register; reset parks at the last pixel so the first enable wraps to (0,0)
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            blank_q       <= 1'b0;
            hs_raw_q      <= 1'b1;
            vs_raw_q      <= 1'b1;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            blank_q       <= blank_d;
            hs_raw_q      <= hs_raw_d;
            vs_raw_q      <= vs_raw_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    // syncs lag by the renderers' colour register; blank stays aligned with DrawX/DrawY
    sync_delay_line #(.WIDTH(2), .DEPTH(SYNC_DELAY)) u_sync_dly (
        .clk     (vga_clk),
        .reset_n (reset_n),
        .d       ({hs_raw_q, vs_raw_q}),
        .q       (sync_dly)
    );

    assign vif.DrawX       = hc_q;
    assign vif.DrawY       = vc_q;
    assign vif.blank       = blank_q;
    assign vif.hs          = sync_dly[1];
    assign vif.vs          = sync_dly[0];
    assign vif.sync        = 1'b0;
    assign vif.frame_start = frame_start_q;
    assign vif.line_start  = line_start_q;

endmodule
